// File: rtl/text_line_buffer_pkg.sv
// Shared definitions for the writable text line buffer.
// Command encodings, controller states and the default fill code.
package text_line_buffer_pkg;

   typedef enum logic [1:0] {
      OP_PUT   = 2'b00,
      OP_BS    = 2'b01,
      OP_CLEAR = 2'b10,
      OP_HOME  = 2'b11
   } cmd_op_e;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

   localparam logic [7:0] FILL_DEF = 8'h20;

endpackage

// File: rtl/text_line_buffer_text_ram.sv
// Character storage: one write port, registered read-first read port.
// Ports: clk, we/waddr/wdata write side, raddr in, rdata registered out.
module text_ram
   import text_line_buffer_pkg::*;
#(
   parameter int LEN = 16,
   parameter int AW  = 4,
   parameter int DW  = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   // No reset on storage so it maps onto block RAM.
   logic [DW-1:0] mem [LEN];

   // Non-blocking read and write on the same edge gives read-first.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/text_line_buffer.sv
// Cursor-driven character line buffer feeding the font renderer.
// Ports: clk, rstn, cmd_* handshake, rd_index/rd_char, cursor, busy, full, overflow.
module text_line_buffer
   import text_line_buffer_pkg::*;
#(
   parameter int          LEN  = 16,
   parameter int          AW   = 4,
   parameter int          DW   = 8,
   parameter logic [DW-1:0] FILL = DW'(FILL_DEF),
   parameter bit          WRAP = 1'b1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [DW-1:0] cmd_char,
   input  logic [AW-1:0] rd_index,
   output logic [DW-1:0] rd_char,
   output logic [AW-1:0] cursor,
   output logic          busy,
   output logic          full,
   output logic          overflow
);

   localparam logic [AW-1:0] LAST  = AW'(LEN - 1);
   localparam logic [AW:0]   LEN_W = (AW + 1)'(LEN);

   state_e        state_q, state_d;
   logic [AW-1:0] cursor_q, cursor_d;
   logic [AW-1:0] clr_addr_q, clr_addr_d;
   logic          full_q, full_d;
   logic          overflow_q, overflow_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          fill_q, fill_d;

   logic          accept;
   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] ram_rdata;

   assign accept = cmd_valid && ready_q;

   always_comb begin
      state_d    = state_q;
      cursor_d   = cursor_q;
      clr_addr_d = clr_addr_q;
      full_d     = full_q;
      overflow_d = overflow_q;
      we         = 1'b0;
      waddr      = cursor_q;
      wdata      = FILL;

      if (state_q == ST_CLEAR) begin
         we         = 1'b1;
         waddr      = clr_addr_q;
         clr_addr_d = clr_addr_q + AW'(1);
         if (clr_addr_q == LAST) begin
            state_d    = ST_IDLE;
            clr_addr_d = '0;
         end
      end else if (accept) begin
         unique case (cmd_op_e'(cmd_op))
            OP_PUT: begin
               if (full_q) begin
                  overflow_d = 1'b1;
               end else begin
                  we    = 1'b1;
                  wdata = cmd_char;
                  if (cursor_q == LAST) begin
                     if (WRAP) cursor_d = '0;
                     else      full_d   = 1'b1;
                  end else begin
                     cursor_d = cursor_q + AW'(1);
                  end
               end
            end
            OP_BS: begin
               // When full the cursor already sits on the last cell.
               if (full_q) begin
                  full_d = 1'b0;
                  we     = 1'b1;
                  waddr  = LAST;
               end else if (cursor_q != '0) begin
                  cursor_d = cursor_q - AW'(1);
                  we       = 1'b1;
                  waddr    = cursor_q - AW'(1);
               end
            end
            OP_CLEAR: begin
               cursor_d   = '0;
               full_d     = 1'b0;
               overflow_d = 1'b0;
               clr_addr_d = '0;
               state_d    = ST_CLEAR;
            end
            OP_HOME: begin
               cursor_d = '0;
               full_d   = 1'b0;
            end
            default: ;
         endcase
      end

      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d == ST_CLEAR);
      // Mask RAM data for out-of-range reads and for the whole clear
      // window, including the edge that finishes the last clear write.
      fill_d  = ({1'b0, rd_index} >= LEN_W) ||
                (state_d == ST_CLEAR) || (state_q == ST_CLEAR);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_CLEAR;
         cursor_q   <= '0;
         clr_addr_q <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b1;
         fill_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         cursor_q   <= cursor_d;
         clr_addr_q <= clr_addr_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         fill_q     <= fill_d;
      end
   end

   text_ram #(
      .LEN (LEN),
      .AW  (AW),
      .DW  (DW)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (rd_index),
      .rdata (ram_rdata)
   );

   assign cmd_ready = ready_q;
   assign busy      = busy_q;
   assign cursor    = cursor_q;
   assign full      = full_q;
   assign overflow  = overflow_q;
   assign rd_char   = fill_q ? FILL : ram_rdata;

endmodule

// File: tb/tb_text_line_buffer.sv
// Directed bench for text_line_buffer, wrap and saturate builds side by side.
// Both instances share stimulus; each is checked against its own expectations.
module tb_text_line_buffer;
   import text_line_buffer_pkg::*;

   logic       clk = 1'b0;
   logic       rstn;
   logic       cmd_valid;
   logic [1:0] cmd_op;
   logic [7:0] cmd_char;
   logic [3:0] rd_index;

   logic       w_ready, w_busy, w_full, w_ovf;
   logic [7:0] w_rd;
   logic [3:0] w_cur;
   logic       n_ready, n_busy, n_full, n_ovf;
   logic [7:0] n_rd;
   logic [3:0] n_cur;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   text_line_buffer #(.WRAP(1'b1)) u_wrap (
      .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(w_ready),
      .cmd_op(cmd_op), .cmd_char(cmd_char), .rd_index(rd_index),
      .rd_char(w_rd), .cursor(w_cur), .busy(w_busy), .full(w_full),
      .overflow(w_ovf)
   );

   text_line_buffer #(.WRAP(1'b0)) u_nowrap (
      .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(n_ready),
      .cmd_op(cmd_op), .cmd_char(cmd_char), .rd_index(rd_index),
      .rd_char(n_rd), .cursor(n_cur), .busy(n_busy), .full(n_full),
      .overflow(n_ovf)
   );

   typedef struct {
      logic [1:0] op;
      logic [7:0] ch;
      logic [3:0] cur;
   } cmd_vec_t;

   typedef struct {
      logic [3:0] idx;
      logic [7:0] exp;
   } rd_vec_t;

   cmd_vec_t cv[5];
   rd_vec_t  rv[6];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [7:0] ch);
      int n;
      @(negedge clk);
      n = 0;
      while (!w_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         tests++;
         fails++;
         $display("FAIL issue_timeout: got %0d cycles expected <100", n);
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_char  = ch;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic rd(input logic [3:0] idx);
      @(negedge clk);
      rd_index = idx;
      @(negedge clk);
   endtask

   task automatic wait_clear(input string name);
      int n;
      n = 0;
      while (w_busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      check(name, n, 16);
      check({name, "_ready"}, w_ready, 1);
      check({name, "_n_ready"}, n_ready, 1);
   endtask

   initial begin
      cv[0] = '{2'b00, 8'h41, 4'd1};
      cv[1] = '{2'b00, 8'h6c, 4'd2};
      cv[2] = '{2'b00, 8'h65, 4'd3};
      cv[3] = '{2'b00, 8'h78, 4'd4};
      cv[4] = '{2'b00, 8'h21, 4'd5};
      rv[0] = '{4'd0, 8'h41};
      rv[1] = '{4'd1, 8'h6c};
      rv[2] = '{4'd2, 8'h65};
      rv[3] = '{4'd3, 8'h78};
      rv[4] = '{4'd4, 8'h21};
      rv[5] = '{4'd5, 8'h20};

      rstn      = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_char  = 8'h00;
      rd_index  = 4'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", w_busy, 1);
      check("rst_ready", w_ready, 0);
      check("rst_cursor", w_cur, 0);
      check("rst_full", n_full, 0);
      check("rst_ovf", n_ovf, 0);
      check("rst_rd", w_rd, 8'h20);

      rstn = 1'b1;
      wait_clear("clear_len");
      for (int i = 0; i < 16; i++) begin
         rd(4'(i));
         check($sformatf("init_rd%0d", i), w_rd, 8'h20);
      end

      for (int i = 0; i < 5; i++) begin
         issue(cv[i].op, cv[i].ch);
         check($sformatf("put_cur%0d", i), w_cur, cv[i].cur);
         check($sformatf("put_ncur%0d", i), n_cur, cv[i].cur);
      end
      for (int i = 0; i < 6; i++) begin
         rd(rv[i].idx);
         check($sformatf("alex_rd%0d", i), w_rd, rv[i].exp);
      end

      issue(OP_HOME, 8'h00);
      check("home_cur", w_cur, 0);
      for (int i = 0; i < 17; i++) issue(OP_PUT, 8'(8'h30 + i));
      check("wrap_cur", w_cur, 1);
      check("wrap_full", w_full, 0);
      check("wrap_ovf", w_ovf, 0);
      check("sat_cur", n_cur, 15);
      check("sat_full", n_full, 1);
      check("sat_ovf", n_ovf, 1);
      rd(4'd0);
      check("wrap_cell0", w_rd, 8'h40);
      check("sat_cell0", n_rd, 8'h30);
      rd(4'd1);
      check("wrap_cell1", w_rd, 8'h31);
      rd(4'd15);
      check("sat_cell15", n_rd, 8'h3f);

      issue(OP_BS, 8'h00);
      check("bs1_sat_full", n_full, 0);
      check("bs1_sat_cur", n_cur, 15);
      check("bs1_wrap_cur", w_cur, 0);
      issue(OP_BS, 8'h00);
      check("bs2_sat_cur", n_cur, 14);
      check("bs2_wrap_cur", w_cur, 0);
      check("bs2_sat_ovf", n_ovf, 1);
      rd(4'd14);
      check("bs_cell14", n_rd, 8'h20);
      rd(4'd15);
      check("bs_cell15", n_rd, 8'h20);
      rd(4'd0);
      check("bs_wrap_cell0", w_rd, 8'h20);
      rd(4'd1);
      check("bs_wrap_cell1", w_rd, 8'h31);

      issue(OP_HOME, 8'h00);
      issue(OP_PUT, 8'h61);
      issue(OP_PUT, 8'h62);
      issue(OP_PUT, 8'h63);
      check("rf_cur", w_cur, 3);
      @(negedge clk);
      rd_index  = 4'd3;
      cmd_valid = 1'b1;
      cmd_op    = OP_PUT;
      cmd_char  = 8'h5a;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("rf_old", w_rd, 8'h33);
      check("rf_old_n", n_rd, 8'h33);
      @(negedge clk);
      check("rf_new", w_rd, 8'h5a);

      issue(OP_CLEAR, 8'h00);
      check("clr_busy", w_busy, 1);
      check("clr_ready", w_ready, 0);
      check("clr_ovf", n_ovf, 0);
      check("clr_cur", w_cur, 0);
      check("clr_rd", w_rd, 8'h20);
      repeat (5) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      check("mid_rst_busy", w_busy, 1);
      check("mid_rst_ready", w_ready, 0);
      check("mid_rst_cur", w_cur, 0);
      check("mid_rst_rd", w_rd, 8'h20);
      @(negedge clk);
      rstn = 1'b1;
      wait_clear("reclear_len");
      check("reclear_ovf", n_ovf, 0);
      for (int i = 0; i < 16; i++) begin
         rd(4'(i));
         check($sformatf("reclr_rd%0d", i), w_rd, 8'h20);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/text_line_buffer.md
Name: text_line_buffer

Overview:
- Writable, parametrised character line buffer.
- Successor to the fixed hard-coded string ROM that feeds the font renderer.
- A host or UART side writes characters through a cursor-based valid/ready command port.
- The VGA/font renderer reads any cell by index with fixed one-cycle latency.
- Adds runtime clearing, backspace, cursor home, and wrap or saturate mode, none of which a fixed string ROM has.

Parameters:
- LEN, 16: number of character cells; 2..256, need not be a power of two.
- AW, 4: index/cursor width; must satisfy 2^AW >= LEN.
- DW, 8: character code width.
- FILL, 8'h20: code written on clear and backspace (ASCII space).
- WRAP, 1: 1 = cursor wraps LEN-1 -> 0; 0 = cursor saturates and sets the full flag.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_op  in  2  00 PUT, 01 BACKSPACE, 10 CLEAR, 11 HOME.
- cmd_char  in  DW  character for PUT; ignored for other ops.
- rd_index  in  AW  renderer read address.
- rd_char  out  DW  registered read data.
- cursor  out  AW  current write position.
- busy  out  1  clear sequence in progress.
- full  out  1  WRAP=0 only: last cell written, further PUTs dropped.
- overflow  out  1  sticky: a PUT was dropped while full.

Behaviour:
- Reset (rstn=0, asynchronous): cursor=0, full=0, overflow=0, rd_char=FILL, cmd_ready=0, busy=1, state=CLEAR, clear address=0.
  - Memory contents are not reset directly; the CLEAR sequence initialises them after reset release.
- States: CLEAR and IDLE.
- CLEAR:
  - Writes FILL to address clr_addr, one address per cycle from 0 to LEN-1.
  - Takes exactly LEN cycles, then moves to IDLE.
  - busy=1 and cmd_ready=0 throughout.
  - rd_char is forced to FILL.
- IDLE: busy=0, cmd_ready=1. A command is accepted on a cycle with cmd_valid && cmd_ready.
- PUT:
  - Write mem[cursor]=cmd_char.
  - If cursor<LEN-1: cursor+1.
  - At LEN-1 with WRAP=1: cursor=0.
  - At LEN-1 with WRAP=0: cursor stays at LEN-1 and full=1.
  - PUT while full: no write, overflow=1 (sticky until CLEAR or reset).
- BACKSPACE:
  - If full: full=0, write FILL at LEN-1, cursor unchanged.
  - Else if cursor>0: cursor-1, then write FILL at the new cursor.
  - Else (cursor=0): no-op. There is no wrap backwards, even with WRAP=1.
- CLEAR: cursor=0, full=0, overflow=0, clr_addr=0, go to CLEAR. The cycle after acceptance has busy=1.
- HOME: cursor=0, full=0. Memory and overflow unchanged.
- Read port:
  - rd_char <= mem[rd_index] each cycle: one-cycle latency, independent of the command port.
  - rd_index>=LEN returns FILL.
  - A read and write to the same address in the same cycle returns the old data (read-first).
- cursor, full and overflow update on the edge that accepts the command.
- Reset asserted mid-CLEAR or mid-command aborts immediately, and a full CLEAR restarts after release.

Decomposition:
- Shared package: cmd_op encodings (OP_PUT, OP_BS, OP_CLEAR, OP_HOME), state encoding, FILL default.
- One sub-module, text_ram: single write port, registered read-first read port, DW x LEN.
  - No reset on its storage, so it infers block RAM.
- Control FSM, cursor and flags stay in text_line_buffer.

Test Plan:
- Reset release, LEN=16 -> busy=1 and cmd_ready=0 for exactly 16 cycles; then reads of indices 0..15 all return 8'h20 one cycle after the address.
- PUT 'A','l','e','x','!' -> cursor=5; rd_index 0..4 return 41,6c,65,78,21; rd_index 5 returns 20.
- WRAP=1, 17 PUTs of 8'h30+i -> cursor=1, cell 0 = 8'h40, cell 1 = 8'h31. WRAP=0, 17 PUTs -> full=1, overflow=1, cell 15 = 8'h3F, cursor=15.
- WRAP=0 full, then BACKSPACE x2 -> full=0, cursor=14, cells 14 and 15 = 20. BACKSPACE at cursor=0 -> no change.
- Write 'Z' at index 3 while rd_index=3 on the same cycle -> rd_char shows old value next cycle, 'Z' the cycle after.
- CLEAR mid-line, then pulse rstn low mid-CLEAR -> outputs reach reset values asynchronously; a fresh 16-cycle clear follows; overflow=0.
